// File: rtl/regbank_writeback_pkg.sv
// rtl/regbank_writeback_pkg.sv - shared writeback kind and state encodings
package regbank_writeback_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_IDX_W = 4;
  localparam int DATA_W = 32;

  // Retiring instruction kinds as delivered by execute/memory
  typedef enum logic [1:0] {
    WB_KIND_NONE    = 2'd0,
    WB_KIND_ALU     = 2'd1,
    WB_KIND_LOADHI  = 2'd2,
    WB_KIND_MEMLOAD = 2'd3
  } wb_kind_t;

  // Writeback control states
  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_pending_scoreboard.sv
// rtl/wb_pending_scoreboard.sv - pending-load scoreboard with two hazard lookups
module wb_pending_scoreboard
  import regbank_writeback_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] query_a,
  input  logic [REG_IDX_W-1:0] query_b,
  output logic                 hazard_a,
  output logic                 hazard_b,
  output logic [NUM_REGS-1:0]  pending
);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] pend_q;

  // Decode the one-hot set and clear requests
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  // Clear first, then set, so a set is never lost; r0 is never tracked
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= ((pend_q & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
    end
  end

  assign pending  = pend_q;
  assign hazard_a = pend_q[query_a] && (query_a != '0);
  assign hazard_b = pend_q[query_b] && (query_b != '0);

endmodule

// File: rtl/regbank_writeback.sv
// rtl/regbank_writeback.sv - writeback stage driving the regbank write port; optional REGBANK_WB_LOAD_TIMEOUT_EN
module regbank_writeback
  import regbank_writeback_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_kind,
  input  logic [REG_IDX_W-1:0] in_dreg,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 mem_rdata_valid,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [REG_IDX_W-1:0] addr_d,
  output logic [DATA_W-1:0]    data_d,
  output logic                 we,
  output logic                 we_high,
  input  logic [REG_IDX_W-1:0] query_a,
  input  logic [REG_IDX_W-1:0] query_b,
  output logic                 hazard_a,
  output logic                 hazard_b,
  output logic [NUM_REGS-1:0]  pending,
  output logic                 err_timeout
);

  wb_state_t            state, state_next;
  wb_kind_t             kind;
  logic [REG_IDX_W-1:0] dreg_q, dreg_next;
  logic [REG_IDX_W-1:0] addr_next;
  logic [DATA_W-1:0]    data_next;
  logic                 we_next, we_high_next;
  logic                 set_en, clr_en;
  logic                 timeout_hit;

  assign kind     = wb_kind_t'(in_kind);
  assign in_ready = (state == WB_IDLE);

`ifdef REGBANK_WB_LOAD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;

  assign timeout_hit = (tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES));

  // Count WAIT_MEM cycles without data; restart whenever the wait ends
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state == WB_WAIT_MEM && !mem_rdata_valid && !timeout_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Sticky abort flag; data on the limit cycle takes precedence
  always_ff @(posedge clk) begin
    if (reset) begin
      err_timeout <= 1'b0;
    end else if (state == WB_WAIT_MEM && !mem_rdata_valid && timeout_hit) begin
      err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  // Without the timeout the parameters only carry a width sanity term
  assign err_timeout = 1'b0 && (TIMEOUT_CYCLES < (1 << TIMEOUT_W));
`endif

  // Next-state and next write-port values; r0 never gets a write pulse
  always_comb begin
    state_next   = state;
    dreg_next    = dreg_q;
    addr_next    = addr_d;
    data_next    = data_d;
    we_next      = 1'b0;
    we_high_next = 1'b0;
    set_en       = 1'b0;
    clr_en       = 1'b0;
    unique case (state)
      WB_IDLE: begin
        if (in_valid) begin
          unique case (kind)
            WB_KIND_ALU: begin
              if (in_dreg != '0) begin
                we_next   = 1'b1;
                addr_next = in_dreg;
                data_next = in_data;
              end
            end
            WB_KIND_LOADHI: begin
              if (in_dreg != '0) begin
                we_next      = 1'b1;
                we_high_next = 1'b1;
                addr_next    = in_dreg;
                data_next    = {16'h0000, in_data[15:0]};
              end
            end
            WB_KIND_MEMLOAD: begin
              dreg_next  = in_dreg;
              set_en     = 1'b1;
              state_next = WB_WAIT_MEM;
            end
            default: ;
          endcase
        end
      end
      WB_WAIT_MEM: begin
        if (mem_rdata_valid) begin
          clr_en     = 1'b1;
          state_next = WB_IDLE;
          if (dreg_q != '0) begin
            we_next   = 1'b1;
            addr_next = dreg_q;
            data_next = mem_rdata;
          end
        end else if (timeout_hit) begin
          clr_en     = 1'b1;
          state_next = WB_IDLE;
        end
      end
      default: state_next = WB_IDLE;
    endcase
  end

  // State and registered write-port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= WB_IDLE;
      dreg_q  <= '0;
      addr_d  <= '0;
      data_d  <= '0;
      we      <= 1'b0;
      we_high <= 1'b0;
    end else begin
      state   <= state_next;
      dreg_q  <= dreg_next;
      addr_d  <= addr_next;
      data_d  <= data_next;
      we      <= we_next;
      we_high <= we_high_next;
    end
  end

  wb_pending_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (set_en),
    .set_idx  (in_dreg),
    .clr_en   (clr_en),
    .clr_idx  (dreg_q),
    .query_a  (query_a),
    .query_b  (query_b),
    .hazard_a (hazard_a),
    .hazard_b (hazard_b),
    .pending  (pending)
  );

endmodule

// File: tb/tb_regbank_writeback.sv
// tb/tb_regbank_writeback.sv - directed self-checking bench for regbank_writeback
module tb_regbank_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [3:0]  in_dreg;
  logic [31:0] in_data;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic [3:0]  addr_d;
  logic [31:0] data_d;
  logic        we;
  logic        we_high;
  logic [3:0]  query_a;
  logic [3:0]  query_b;
  logic        hazard_a;
  logic        hazard_b;
  logic [15:0] pending;
  logic        err_timeout;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regbank_writeback #(.TIMEOUT_CYCLES(8), .TIMEOUT_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_kind         (in_kind),
    .in_dreg         (in_dreg),
    .in_data         (in_data),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .addr_d          (addr_d),
    .data_d          (data_d),
    .we              (we),
    .we_high         (we_high),
    .query_a         (query_a),
    .query_b         (query_b),
    .hazard_a        (hazard_a),
    .hazard_b        (hazard_b),
    .pending         (pending),
    .err_timeout     (err_timeout)
  );

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_kind = 2'd0; in_dreg = 4'd0; in_data = '0;
    mem_rdata_valid = 1'b0; mem_rdata = '0; query_a = 4'd0; query_b = 4'd0;
    repeat (3) @(negedge clk);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0h want=0", we); end
    total++; if (we_high !== 1'b0) begin bad++; $display("FAIL reset_we_high got=%0h want=0", we_high); end
    total++; if (addr_d !== 4'd0) begin bad++; $display("FAIL reset_addr got=%0h want=0", addr_d); end
    total++; if (data_d !== 32'h0) begin bad++; $display("FAIL reset_data got=%0h want=0", data_d); end
    total++; if (pending !== 16'h0) begin bad++; $display("FAIL reset_pending got=%0h want=0", pending); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err got=%0h want=0", err_timeout); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h want=1", in_ready); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu();
    in_valid = 1'b1; in_kind = 2'd1; in_dreg = 4'd5; in_data = 32'h12345678;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL alu_we got=%0h want=1", we); end
    total++; if (we_high !== 1'b0) begin bad++; $display("FAIL alu_we_high got=%0h want=0", we_high); end
    total++; if (addr_d !== 4'd5) begin bad++; $display("FAIL alu_addr got=%0h want=5", addr_d); end
    total++; if (data_d !== 32'h12345678) begin bad++; $display("FAIL alu_data got=%0h want=12345678", data_d); end
    @(negedge clk);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL alu_we_drop got=%0h want=0", we); end
    total++; if (addr_d !== 4'd5) begin bad++; $display("FAIL alu_addr_hold got=%0h want=5", addr_d); end
  endtask

  task automatic test_loadhi();
    in_valid = 1'b1; in_kind = 2'd2; in_dreg = 4'd3; in_data = 32'hFFFFABCD;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL loadhi_we got=%0h want=1", we); end
    total++; if (we_high !== 1'b1) begin bad++; $display("FAIL loadhi_we_high got=%0h want=1", we_high); end
    total++; if (addr_d !== 4'd3) begin bad++; $display("FAIL loadhi_addr got=%0h want=3", addr_d); end
    total++; if (data_d !== 32'h0000ABCD) begin bad++; $display("FAIL loadhi_data got=%0h want=0000abcd", data_d); end
    @(negedge clk);
    total++; if (we_high !== 1'b0) begin bad++; $display("FAIL loadhi_we_high_drop got=%0h want=0", we_high); end
  endtask

  task automatic test_memload();
    in_valid = 1'b1; in_kind = 2'd3; in_dreg = 4'd7; query_a = 4'd7; query_b = 4'd6;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ml_ready got=%0h want=0", in_ready); end
    total++; if (pending !== 16'h0080) begin bad++; $display("FAIL ml_pending got=%0h want=0080", pending); end
    total++; if (hazard_a !== 1'b1) begin bad++; $display("FAIL ml_hazard_a got=%0h want=1", hazard_a); end
    total++; if (hazard_b !== 1'b0) begin bad++; $display("FAIL ml_hazard_b got=%0h want=0", hazard_b); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0 || we !== 1'b0) begin bad++; $display("FAIL ml_wait%0d ready=%0h we=%0h want 0 0", i, in_ready, we); end
    end
    mem_rdata_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL ml_we got=%0h want=1", we); end
    total++; if (addr_d !== 4'd7) begin bad++; $display("FAIL ml_addr got=%0h want=7", addr_d); end
    total++; if (data_d !== 32'hDEADBEEF) begin bad++; $display("FAIL ml_data got=%0h want=deadbeef", data_d); end
    total++; if (pending !== 16'h0) begin bad++; $display("FAIL ml_pending_clr got=%0h want=0", pending); end
    total++; if (hazard_a !== 1'b0) begin bad++; $display("FAIL ml_hazard_clr got=%0h want=0", hazard_a); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ml_ready_back got=%0h want=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_kind = 2'd3; in_dreg = 4'd6;
    @(negedge clk);
    in_kind = 2'd1; in_dreg = 4'd2; in_data = 32'h00000055;
    @(negedge clk);
    total++; if (we !== 1'b0 || pending !== 16'h0040) begin bad++; $display("FAIL b2b_wait we=%0h pending=%0h want 0 0040", we, pending); end
    mem_rdata_valid = 1'b1; mem_rdata = 32'hCAFE0001;
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    total++; if (we !== 1'b1 || addr_d !== 4'd6 || data_d !== 32'hCAFE0001) begin bad++; $display("FAIL b2b_load we=%0h addr=%0h data=%0h want 1 6 cafe0001", we, addr_d, data_d); end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (we !== 1'b1 || addr_d !== 4'd2 || data_d !== 32'h00000055) begin bad++; $display("FAIL b2b_alu we=%0h addr=%0h data=%0h want 1 2 55", we, addr_d, data_d); end
    @(negedge clk);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL b2b_idle we=%0h want 0", we); end
  endtask

  task automatic test_r0();
    in_valid = 1'b1; in_kind = 2'd1; in_dreg = 4'd0; in_data = 32'h11111111; query_a = 4'd0;
    @(negedge clk);
    total++; if (we !== 1'b0 || addr_d !== 4'd2) begin bad++; $display("FAIL r0_alu we=%0h addr=%0h want 0 2", we, addr_d); end
    in_kind = 2'd3;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL r0_ml_ready got=%0h want=0", in_ready); end
    total++; if (pending !== 16'h0 || hazard_a !== 1'b0) begin bad++; $display("FAIL r0_ml_pending pending=%0h hazard=%0h want 0 0", pending, hazard_a); end
    mem_rdata_valid = 1'b1; mem_rdata = 32'h22222222;
    @(negedge clk);
    total++; if (we !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL r0_ml_ret we=%0h ready=%0h want 0 1", we, in_ready); end
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    total++; if (we !== 1'b0 || data_d !== 32'h00000055) begin bad++; $display("FAIL stray_data we=%0h data=%0h want 0 55", we, data_d); end
  endtask

  task automatic test_reset_in_wait();
    in_valid = 1'b1; in_kind = 2'd3; in_dreg = 4'd4;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (pending !== 16'h0010) begin bad++; $display("FAIL rw_pending got=%0h want=0010", pending); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (pending !== 16'h0 || in_ready !== 1'b1) begin bad++; $display("FAIL rw_abort pending=%0h ready=%0h want 0 1", pending, in_ready); end
    mem_rdata_valid = 1'b1; mem_rdata = 32'h33333333;
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    total++; if (we !== 1'b0 || pending !== 16'h0 || in_ready !== 1'b1) begin bad++; $display("FAIL rw_late we=%0h pending=%0h ready=%0h want 0 0 1", we, pending, in_ready); end
  endtask

`ifdef REGBANK_WB_LOAD_TIMEOUT_EN
  task automatic test_timeout();
    in_valid = 1'b1; in_kind = 2'd3; in_dreg = 4'd10;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    mem_rdata_valid = 1'b1; mem_rdata = 32'h44444444;
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    total++; if (we !== 1'b1 || addr_d !== 4'd10 || err_timeout !== 1'b0) begin bad++; $display("FAIL to_edge_data we=%0h addr=%0h err=%0h want 1 a 0", we, addr_d, err_timeout); end
    in_valid = 1'b1; in_kind = 2'd3; in_dreg = 4'd9;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (pending !== 16'h0200) begin bad++; $display("FAIL to_pending got=%0h want=0200", pending); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0 || err_timeout !== 1'b0) begin bad++; $display("FAIL to_wait%0d ready=%0h err=%0h want 0 0", i, in_ready, err_timeout); end
    end
    @(negedge clk);
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err got=%0h want=1", err_timeout); end
    total++; if (pending !== 16'h0 || in_ready !== 1'b1 || we !== 1'b0) begin bad++; $display("FAIL to_abort pending=%0h ready=%0h we=%0h want 0 1 0", pending, in_ready, we); end
    @(negedge clk);
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%0h want=1", err_timeout); end
  endtask
`else
  task automatic test_timeout();
    in_valid = 1'b1; in_kind = 2'd3; in_dreg = 4'd9;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clk);
    total++; if (in_ready !== 1'b0 || pending !== 16'h0200 || err_timeout !== 1'b0) begin bad++; $display("FAIL nto_wait ready=%0h pending=%0h err=%0h want 0 0200 0", in_ready, pending, err_timeout); end
    mem_rdata_valid = 1'b1; mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    total++; if (we !== 1'b1 || addr_d !== 4'd9 || data_d !== 32'h0BADF00D) begin bad++; $display("FAIL nto_data we=%0h addr=%0h data=%0h want 1 9 0badf00d", we, addr_d, data_d); end
    total++; if (err_timeout !== 1'b0 || pending !== 16'h0) begin bad++; $display("FAIL nto_err err=%0h pending=%0h want 0 0", err_timeout, pending); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_loadhi();
    test_memload();
    test_back_to_back();
    test_r0();
    test_reset_in_wait();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regbank_writeback.md
Name: regbank_writeback

Overview:
- CPU writeback stage directly upstream of the register bank; sole driver of the bank's write port (addr_d, data_d, we, we_high).
- Accepts retiring instructions from the execute/memory stage over a valid/ready handshake.
- Waits for variable-latency memory load data.
- Keeps a pending-load scoreboard so decode can detect read-after-load hazards.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT_MEM cycles before abort; only used with the optional feature.
- TIMEOUT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has a retiring instruction.
- in_ready  out  1  stage can accept; equals (state==IDLE).
- in_kind  in  2  0=NONE (no write), 1=ALU full write, 2=LOADHI, 3=MEMLOAD.
- in_dreg  in  4  destination register.
- in_data  in  32  ALU result / LOADHI immediate in [15:0].
- mem_rdata_valid  in  1  load data present this cycle.
- mem_rdata  in  32  load data.
- addr_d  out  4  to regbank.
- data_d  out  32  to regbank.
- we  out  1  to regbank; one-cycle write pulse.
- we_high  out  1  to regbank; high-half-only write.
- query_a, query_b  in  4  decode source registers.
- hazard_a, hazard_b  out  1  combinational: pending[query_x] && query_x!=0.
- pending  out  16  scoreboard; bit n = load to rn outstanding.
- err_timeout  out  1  sticky load-timeout flag.

Behaviour:
- Reset (synchronous, active-high, clk edge): state=IDLE; addr_d=0, data_d=0, we=0, we_high=0, pending=0, err_timeout=0, timeout counter=0. Reset in WAIT_MEM aborts the load; a later mem_rdata_valid is ignored.
- Outputs are registered. we and we_high default to 0 every cycle. addr_d and data_d hold their last values when no write occurs.
- Acceptance: in_valid && in_ready at edge N.
- ALU: cycle N+1 drives we=1, we_high=0, addr_d=in_dreg, data_d=in_data.
- LOADHI: cycle N+1 drives we=1, we_high=1, data_d={16'h0, in_data[15:0]}.
- NONE: no write; stays IDLE.
- MEMLOAD: latch in_dreg; set pending[in_dreg]; go to WAIT_MEM; in_ready=0.
- In WAIT_MEM, mem_rdata_valid sampled at edge M causes, in cycle M+1: we=1, we_high=0, addr_d=latched dreg, data_d=mem_rdata; pending bit cleared; state=IDLE.
- in_ready is 1 again in cycle M+1. There is no same-cycle accept on data return.
- mem_rdata_valid in IDLE: ignored, no write.
- Register 0: any kind with dreg 0 produces no we pulse. A MEMLOAD to r0 still waits for data; pending[0] is never set.
- hazard_x is purely combinational from pending. The hazard clears in the same cycle the we pulse is presented, so bank bypass covers the read.
- States: IDLE -> WAIT_MEM (accepted MEMLOAD); WAIT_MEM -> IDLE (mem_rdata_valid, timeout, or reset).

Optional Feature:
- Macro: REGBANK_WB_LOAD_TIMEOUT_EN.
- When defined: a counter increments each WAIT_MEM cycle without data. When it reaches TIMEOUT_CYCLES, the stage returns to IDLE next edge, performs no write, clears the pending bit, and sets err_timeout=1 (sticky until reset). Data arriving on the exact timeout cycle wins: normal write, no error.
- When undefined: WAIT_MEM waits indefinitely, no counter is synthesised, err_timeout is tied 0.

Decomposition:
- Shared CPU defines header: kind encodings (WB_KIND_NONE/ALU/LOADHI/MEMLOAD) and state encodings (WB_IDLE, WB_WAIT_MEM).
- One sub-module: wb_pending_scoreboard.
  - Holds the 16-bit set/clear register; set has priority over clear for different bits.
  - Provides the two combinational hazard lookups.
  - Bit 0 is forced to 0.

Test Plan:
- Reset, then ALU in_dreg=5, in_data=32'h12345678 -> next cycle we=1, we_high=0, addr_d=5, data_d=32'h12345678; following cycle we=0.
- LOADHI in_dreg=3, in_data=32'hFFFFABCD -> next cycle we=1, we_high=1, data_d=32'h0000ABCD.
- MEMLOAD dreg=7, mem_rdata_valid after 4 cycles with 32'hDEADBEEF:
  - while waiting: in_ready=0, pending=16'h0080, query_a=7 gives hazard_a=1.
  - data edge+1: we=1, addr_d=7, data_d=32'hDEADBEEF, pending=0, in_ready=1.
- ALU and MEMLOAD with dreg=0 -> no we pulse; pending stays 0; stray mem_rdata_valid in IDLE produces no write.
- Assert reset during WAIT_MEM, then pulse mem_rdata_valid -> pending=0, state IDLE, no write.
- With REGBANK_WB_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=8, MEMLOAD dreg=9 with no data -> after 8 cycles err_timeout=1, pending[9]=0, in_ready=1, no write.
